mitll_xort_n: RTL and testbench

MITLL_XORT_N -- requirements
Module: mitll_xort_n

---
 rtl/mitll_xort_n.sv | 121 ++++++++++++
 tb/tb_mitll_xort_n.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mitll_xort_n.sv
// mitll_xort_n -- clocked model of a toggle-encoded N-input XOR / parity cell.
//
// All pulses on a, rd, out and dup are level changes (toggle encoding).
// Each a channel is remembered as "arrived" until the next rd pulse.
// When rd pulses, the window is evaluated:
//   MODE 0: fire when exactly one channel arrived (XOR).
//   MODE 1: fire when an odd number of channels arrived (parity).
// A fire toggles out and bumps out_cnt.
// A second pulse on a channel that already arrived toggles dup once.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   a[N]     per-channel toggle-encoded data pulses
//   rd       toggle-encoded readout/evaluate pulse
//   out      toggle-encoded result pulse (registered)
//   dup      toggle-encoded duplicate-pulse flag (registered)
//   arrived  per-channel window state (registered)
//   out_cnt  count of out pulses, wraps modulo 2^CNT_W (registered)

// Per-channel slice: input edge detect plus arrival bit.
module mitll_xort_n_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic rd_pulse,
  output logic pulse,
  output logic arrived,
  output logic collide
);
  logic a_q;

  assign pulse   = a ^ a_q;
  // A repeat pulse inside the window is a duplicate, including one that
  // coincides with rd.
  assign collide = pulse & arrived;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= 1'b0;
      arrived <= 1'b0;
    end else begin
      a_q <= a;
      if (rd_pulse)   arrived <= 1'b0;
      else if (pulse) arrived <= 1'b1;
    end
  end
endmodule

module mitll_xort_n #(
  parameter int N     = 2,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     a,
  input  logic             rd,
  output logic             out,
  output logic             dup,
  output logic [N-1:0]     arrived,
  output logic [CNT_W-1:0] out_cnt
);
  localparam int PW = $clog2(N + 1);

  logic [N-1:0] pulse;
  logic [N-1:0] collide;
  logic [N-1:0] e_vec;
  logic         rd_q;
  logic         rd_pulse;
  logic         fire;

  assign rd_pulse = rd ^ rd_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    mitll_xort_n_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a[i]),
      .rd_pulse (rd_pulse),
      .pulse    (pulse[i]),
      .arrived  (arrived[i]),
      .collide  (collide[i])
    );
  end

  function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
    logic [PW-1:0] pc;
    pc = '0;
    for (int i = 0; i < N; i++) pc = pc + PW'(v[i]);
    return pc;
  endfunction

  // A data pulse landing on the rd edge belongs to the window being closed.
  assign e_vec = arrived | pulse;

  always_comb begin
    fire = 1'b0;
    if (rd_pulse) begin
      if (MODE == 0) fire = (popcnt(e_vec) == PW'(1));
      else           fire = ^e_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      out     <= 1'b0;
      dup     <= 1'b0;
      out_cnt <= '0;
    end else begin
      rd_q <= rd;
      // One dup toggle per edge no matter how many channels collide.
      if (|collide) dup <= ~dup;
      if (fire) begin
        out     <= ~out;
        out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mitll_xort_n.sv
module tb_mitll_xort_n;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // u0: N=2, XOR, 2-bit counter (exercises wrap)
  logic [1:0] a0 = '0;
  logic       rd0 = 1'b0;
  logic       out0, dup0;
  logic [1:0] arr0;
  logic [1:0] cnt0;

  // u1: N=4, parity
  logic [3:0] a1 = '0;
  logic       rd1 = 1'b0;
  logic       out1, dup1;
  logic [3:0] arr1;
  logic [7:0] cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mitll_xort_n #(.N(2), .MODE(0), .CNT_W(2)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a0), .rd(rd0),
    .out(out0), .dup(dup0), .arrived(arr0), .out_cnt(cnt0)
  );

  mitll_xort_n #(.N(4), .MODE(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .rd(rd1),
    .out(out1), .dup(dup1), .arrived(arr1), .out_cnt(cnt1)
  );

  typedef struct {
    logic [3:0] a;
    logic       rd;
    logic       out;
    logic       dup;
    logic [3:0] arr;
    logic [7:0] cnt;
  } vec_t;

  vec_t v0[15];
  vec_t v1[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_u0(input string tag, input logic o, input logic d,
                        input logic [1:0] ar, input logic [1:0] c);
    chk({tag, ".out"}, int'(out0), int'(o));
    chk({tag, ".dup"}, int'(dup0), int'(d));
    chk({tag, ".arrived"}, int'(arr0), int'(ar));
    chk({tag, ".out_cnt"}, int'(cnt0), int'(c));
  endtask

  task automatic step0(input logic [1:0] a, input logic rd);
    a0 = a; rd0 = rd;
    @(posedge clk); #1;
  endtask

  initial begin
    // a (level), rd (level) -> expected out, dup, arrived, out_cnt after the edge
    v0[0]  = '{4'b00, 1'b0, 1'b0, 1'b0, 4'b00, 8'd0}; // idle
    v0[1]  = '{4'b01, 1'b0, 1'b0, 1'b0, 4'b01, 8'd0}; // a0 arrives
    v0[2]  = '{4'b01, 1'b1, 1'b1, 1'b0, 4'b00, 8'd1}; // rd: single -> fire
    v0[3]  = '{4'b11, 1'b1, 1'b1, 1'b0, 4'b10, 8'd1}; // a1 arrives
    v0[4]  = '{4'b10, 1'b1, 1'b1, 1'b0, 4'b11, 8'd1}; // a0 arrives
    v0[5]  = '{4'b10, 1'b0, 1'b1, 1'b0, 4'b00, 8'd1}; // rd: two -> no fire
    v0[6]  = '{4'b11, 1'b0, 1'b1, 1'b0, 4'b01, 8'd1}; // a0 arrives
    v0[7]  = '{4'b10, 1'b0, 1'b1, 1'b1, 4'b01, 8'd1}; // a0 again -> dup
    v0[8]  = '{4'b10, 1'b1, 1'b0, 1'b1, 4'b00, 8'd2}; // rd: single arrival fires
    v0[9]  = '{4'b00, 1'b0, 1'b1, 1'b1, 4'b00, 8'd3}; // a1 with rd -> fire
    v0[10] = '{4'b01, 1'b0, 1'b1, 1'b1, 4'b01, 8'd3}; // a0 arrives
    v0[11] = '{4'b00, 1'b1, 1'b0, 1'b0, 4'b00, 8'd0}; // a0 dup + rd fire, cnt wraps
    v0[12] = '{4'b11, 1'b1, 1'b0, 1'b0, 4'b11, 8'd0}; // both arrive
    v0[13] = '{4'b00, 1'b1, 1'b0, 1'b1, 4'b11, 8'd0}; // both collide -> one dup toggle
    v0[14] = '{4'b00, 1'b0, 1'b0, 1'b1, 4'b00, 8'd0}; // rd: two -> no fire

    v1[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 8'd0};
    v1[1]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0011, 8'd0};
    v1[2]  = '{4'b0111, 1'b0, 1'b0, 1'b0, 4'b0111, 8'd0};
    v1[3]  = '{4'b0111, 1'b1, 1'b1, 1'b0, 4'b0000, 8'd1}; // three -> fire
    v1[4]  = '{4'b0110, 1'b1, 1'b1, 1'b0, 4'b0001, 8'd1};
    v1[5]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 4'b0011, 8'd1};
    v1[6]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 8'd1}; // two -> no fire
    v1[7]  = '{4'b1011, 1'b1, 1'b1, 1'b0, 4'b0000, 8'd1}; // four with rd -> no fire
    v1[8]  = '{4'b0011, 1'b1, 1'b1, 1'b0, 4'b1000, 8'd1};
    v1[9]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000, 8'd2}; // one -> fire

    // reset state
    #2;
    chk_u0("rst", 1'b0, 1'b0, 2'b00, 2'd0);
    chk("rst.u1.arrived", int'(arr1), 0);
    chk("rst.u1.out_cnt", int'(cnt1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      step0(v0[i].a[1:0], v0[i].rd);
      chk_u0($sformatf("u0v%0d", i), v0[i].out, v0[i].dup, v0[i].arr[1:0], v0[i].cnt[1:0]);
      @(negedge clk);
    end

    for (int i = 0; i < 10; i++) begin
      a1 = v1[i].a; rd1 = v1[i].rd;
      @(posedge clk); #1;
      chk($sformatf("u1v%0d.out", i), int'(out1), int'(v1[i].out));
      chk($sformatf("u1v%0d.dup", i), int'(dup1), int'(v1[i].dup));
      chk($sformatf("u1v%0d.arrived", i), int'(arr1), int'(v1[i].arr));
      chk($sformatf("u1v%0d.out_cnt", i), int'(cnt1), int'(v1[i].cnt));
      @(negedge clk);
    end

    // Mid-window reset: pending arrival and dup=1 are discarded at once.
    step0(2'b01, 1'b0);
    chk_u0("prerst", 1'b0, 1'b1, 2'b01, 2'd0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    a0 = 2'b00;
    #1;
    chk_u0("inrst", 1'b0, 1'b0, 2'b00, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step0(2'b00, 1'b0);
    chk_u0("postrst", 1'b0, 1'b0, 2'b00, 2'd0);
    @(negedge clk);
    step0(2'b00, 1'b1);
    chk_u0("postrst.rd", 1'b0, 1'b0, 2'b00, 2'd0);
    @(negedge clk);

    // Input held high through reset counts as one pulse after release.
    rst_n = 1'b0;
    a0 = 2'b10;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    rd0 = 1'b0;
    @(negedge clk);
    step0(2'b10, 1'b0);
    chk_u0("held", 1'b0, 1'b0, 2'b10, 2'd0);
    @(negedge clk);
    step0(2'b10, 1'b1);
    chk_u0("held.rd", 1'b1, 1'b0, 2'b00, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
